// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: NPC select codes (common with the
// hazard unit), FSM state encodings and the IF/ID slot layout.
package fetch_unit_pkg;

  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b100;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_slot_t;

endpackage

// File: rtl/fetch_unit_npc_target.sv
// Next-PC target selection: decodes npc_op into a redirect flag and target.
// Unknown encodings fall through as sequential fetch.
module npc_target
  import fetch_unit_pkg::*;
(
  input  logic [2:0]  npc_op_i,
  input  logic [31:0] npc_imm_i,
  input  logic [31:0] pc_id_i,
  input  logic [31:0] pc_ex_i,
  input  logic [31:0] alu_result_ex_i,
  output logic        redirect_o,
  output logic [31:0] target_o
);

  always_comb begin
    redirect_o = 1'b0;
    target_o   = '0;
    case (npc_op_i)
      NPC_BRANCH: begin
        redirect_o = 1'b1;
        target_o   = pc_ex_i + npc_imm_i;
      end
      NPC_JUMP: begin
        redirect_o = 1'b1;
        target_o   = pc_id_i + npc_imm_i;
      end
      NPC_JALR: begin
        redirect_o = 1'b1;
        target_o   = alu_result_ex_i & ~32'h1;
      end
      default: begin
        redirect_o = 1'b0;
        target_o   = '0;
      end
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, drives the instruction-memory handshake and
// fills IF/ID. At most one request is outstanding; a one-entry skid buffer
// absorbs a response that lands while IF is stalled.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_IF,
  input  logic        flush_IF,
  input  logic [2:0]  npc_op,
  input  logic [31:0] npc_imm,
  input  logic [31:0] pc_ID,
  input  logic [31:0] pc_EX,
  input  logic [31:0] alu_result_EX,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_IF_ID,
  output logic [31:0] instr_IF_ID,
  output logic        valid_IF_ID
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic         pend_valid_q, pend_valid_d;
  logic         drop_q, drop_d;
  fetch_slot_t  buf_q, buf_d;
  logic         buf_valid_q, buf_valid_d;
  fetch_slot_t  ifid_q, ifid_d;
  logic         ifid_valid_q, ifid_valid_d;

  logic         npc_redirect;
  logic         redirect;
  logic [31:0]  target;
  logic         accept;
  logic         buf_fill;

  npc_target u_npc_target (
    .npc_op_i        (npc_op),
    .npc_imm_i       (npc_imm),
    .pc_id_i         (pc_ID),
    .pc_ex_i         (pc_EX),
    .alu_result_ex_i (alu_result_EX),
    .redirect_o      (npc_redirect),
    .target_o        (target)
  );

  // A stalled JAL in ID re-asserts its redirect later, so stalls mask it.
  assign redirect = npc_redirect && !stall_IF;
  assign accept   = (state_q == S_WAIT) && imem_rvalid && !drop_q && !redirect;
  assign buf_fill = accept && stall_IF && !flush_IF;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_pc_d     = req_pc_q;
    pend_pc_d    = pend_pc_q;
    pend_valid_d = pend_valid_q;
    drop_d       = drop_q;
    imem_req     = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redirect) fetch_pc_d = target;
      end
      S_REQ: begin
        imem_req = !buf_valid_q;
        if (imem_req && imem_gnt) begin
          state_d      = S_WAIT;
          req_pc_d     = fetch_pc_q;
          pend_valid_d = 1'b0;
          if (redirect) begin
            fetch_pc_d = target;
            drop_d     = 1'b1;
          end else if (pend_valid_q) begin
            fetch_pc_d = pend_pc_q;
          end else begin
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end else if (imem_req && redirect) begin
          // Request already on the bus must not move; retarget after grant.
          pend_valid_d = 1'b1;
          pend_pc_d    = target;
          drop_d       = 1'b1;
        end else if (redirect) begin
          fetch_pc_d = target;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          drop_d = 1'b0;
          if (redirect) begin
            fetch_pc_d = target;
            state_d    = S_REQ;
          end else if (!buf_valid_q && !buf_fill) begin
            imem_req = 1'b1;
            if (imem_gnt) begin
              req_pc_d   = fetch_pc_q;
              fetch_pc_d = fetch_pc_q + 32'd4;
            end else begin
              state_d = S_REQ;
            end
          end else begin
            state_d = S_REQ;
          end
        end else if (redirect) begin
          fetch_pc_d = target;
          drop_d     = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ifid_d       = ifid_q;
    ifid_valid_d = ifid_valid_q;
    buf_d        = buf_q;
    buf_valid_d  = buf_valid_q;
    if (flush_IF) begin
      ifid_valid_d = 1'b0;
      ifid_d.instr = NOP_INSTR;
      buf_valid_d  = 1'b0;
    end else if (stall_IF) begin
      if (buf_fill) begin
        buf_valid_d = 1'b1;
        buf_d.pc    = req_pc_q;
        buf_d.instr = imem_rdata;
      end
    end else if (buf_valid_q) begin
      ifid_d       = buf_q;
      ifid_valid_d = 1'b1;
      buf_valid_d  = 1'b0;
    end else if (accept) begin
      ifid_d.pc    = req_pc_q;
      ifid_d.instr = imem_rdata;
      ifid_valid_d = 1'b1;
    end else begin
      ifid_valid_d = 1'b0;
      ifid_d.instr = NOP_INSTR;
    end
    if (redirect) buf_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      fetch_pc_q   <= RESET_PC;
      req_pc_q     <= RESET_PC;
      pend_pc_q    <= RESET_PC;
      pend_valid_q <= 1'b0;
      drop_q       <= 1'b0;
      buf_q        <= '{pc: 32'h0, instr: NOP_INSTR};
      buf_valid_q  <= 1'b0;
      ifid_q       <= '{pc: 32'h0, instr: NOP_INSTR};
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_pc_q     <= req_pc_d;
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
      drop_q       <= drop_d;
      buf_q        <= buf_d;
      buf_valid_q  <= buf_valid_d;
      ifid_q       <= ifid_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign imem_addr   = fetch_pc_q;
  assign pc_IF_ID    = ifid_q.pc;
  assign instr_IF_ID = ifid_q.instr;
  assign valid_IF_ID = ifid_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: scripted memory with adjustable latency,
// expected IF/ID stream in a queue checked by an independent monitor.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_IF = 1'b0;
  logic        flush_IF = 1'b0;
  logic [2:0]  npc_op = NPC_PLUS4;
  logic [31:0] npc_imm = '0;
  logic [31:0] pc_ID = '0;
  logic [31:0] pc_EX = '0;
  logic [31:0] alu_result_EX = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] pc_IF_ID;
  logic [31:0] instr_IF_ID;
  logic        valid_IF_ID;

  localparam logic [31:0] NOP = 32'h0000_0013;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] expQ[$];

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .stall_IF(stall_IF), .flush_IF(flush_IF),
    .npc_op(npc_op), .npc_imm(npc_imm), .pc_ID(pc_ID), .pc_EX(pc_EX),
    .alu_result_EX(alu_result_EX), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc_IF_ID(pc_IF_ID), .instr_IF_ID(instr_IF_ID), .valid_IF_ID(valid_IF_ID)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Memory: grant sampled mid-cycle, response after memLatency cycles, rdata = ~addr.
  int          memLatency = 1;
  logic        memPend = 1'b0;
  logic [31:0] memAddr = '0;
  int          memCnt = 0;

  always @(negedge clk) begin
    if (imem_req === 1'b1 && imem_gnt) begin
      memPend = 1'b1;
      memAddr = imem_addr;
      memCnt  = memLatency;
    end
  end

  always @(posedge clk) begin
    #1;
    imem_rvalid = 1'b0;
    if (memPend) begin
      if (memCnt <= 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = ~memAddr;
        memPend     = 1'b0;
      end else begin
        memCnt--;
      end
    end
  end

  // Monitor: each fresh valid IF/ID entry pops the scoreboard; stalled edges must hold.
  logic [31:0] lastPc = '0;
  logic [31:0] lastInstr = '0;
  logic        stallPrev = 1'b0;

  always @(negedge clk) begin
    logic [31:0] e;
    if (valid_IF_ID === 1'b1) begin
      if (stallPrev) begin
        checkOutput("hold_pc", pc_IF_ID, lastPc);
        checkOutput("hold_instr", instr_IF_ID, lastInstr);
      end else if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL ifid_unexpected: got pc %h, want no valid entry", pc_IF_ID);
      end else begin
        e = expQ.pop_front();
        checkOutput("ifid_pc", pc_IF_ID, e);
        checkOutput("ifid_instr", instr_IF_ID, ~e);
        lastPc    = pc_IF_ID;
        lastInstr = instr_IF_ID;
      end
    end
    stallPrev = stall_IF && !flush_IF && !rst;
  end

  task automatic applyStimulus(input logic r, input logic st, input logic fl,
                               input logic [2:0] op, input logic [31:0] imm,
                               input logic [31:0] pid, input logic [31:0] pex,
                               input logic [31:0] alu, input logic g, input int lat);
    @(posedge clk);
    #1;
    rst = r; stall_IF = st; flush_IF = fl; npc_op = op; npc_imm = imm;
    pc_ID = pid; pc_EX = pex; alu_result_EX = alu; imem_gnt = g;
    if (lat > 0) memLatency = lat;
    @(negedge clk);
  endtask

  task automatic plain(input logic g);
    applyStimulus(0, 0, 0, NPC_PLUS4, 0, 0, 0, 0, g, 0);
  endtask

  initial begin
    foreach (expQ[i]) expQ.delete(i);
    expQ = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h28,
             32'h1000, 32'h4, 32'h0, 32'h4};

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req", imem_req, 0);
    checkOutput("rst_addr", imem_addr, 32'h0);
    checkOutput("rst_valid", valid_IF_ID, 0);
    checkOutput("rst_instr", instr_IF_ID, NOP);
    checkOutput("rst_pc", pc_IF_ID, 32'h0);

    plain(1);                                       // c0: leave reset
    checkOutput("c0_req", imem_req, 0);
    plain(1);                                       // c1
    checkOutput("c1_req", imem_req, 1);
    checkOutput("c1_addr", imem_addr, 32'h0);
    plain(1);                                       // c2: back-to-back issue
    checkOutput("c2_req", imem_req, 1);
    checkOutput("c2_addr", imem_addr, 32'h4);
    repeat (3) plain(1);                            // c3..c5
    applyStimulus(0, 1, 0, NPC_PLUS4, 0, 0, 0, 0, 1, 0);   // c6: 0x10 lands during stall
    checkOutput("c6_req", imem_req, 0);
    applyStimulus(0, 1, 0, NPC_PLUS4, 0, 0, 0, 0, 1, 0);   // c7
    checkOutput("c7_req", imem_req, 0);
    plain(1);                                       // c8: buffer drains
    checkOutput("c8_req", imem_req, 0);
    plain(1);                                       // c9
    checkOutput("c9_req", imem_req, 1);
    checkOutput("c9_addr", imem_addr, 32'h14);
    plain(1);                                       // c10
    applyStimulus(0, 0, 0, NPC_PLUS4, 0, 0, 0, 0, 1, 2);   // c11: 0x1C takes 2 cycles
    applyStimulus(0, 0, 1, NPC_BRANCH, 32'h20, 0, 32'h8, 0, 1, 1); // c12: branch to 0x28
    checkOutput("c12_req", imem_req, 0);
    plain(1);                                       // c13: stale 0x1C dropped
    checkOutput("c13_req", imem_req, 1);
    checkOutput("c13_addr", imem_addr, 32'h28);
    plain(1);                                       // c14
    applyStimulus(0, 0, 0, NPC_JALR, 0, 0, 0, 32'h1001, 1, 0); // c15
    checkOutput("c15_req", imem_req, 0);
    plain(1);                                       // c16
    checkOutput("c16_req", imem_req, 1);
    checkOutput("c16_addr", imem_addr, 32'h1000);
    plain(1);                                       // c17
    applyStimulus(0, 1, 0, NPC_JUMP, 32'h8, 32'hFFFF_FFFC, 0, 0, 1, 0); // c18
    checkOutput("c18_req", imem_req, 0);
    applyStimulus(0, 1, 0, NPC_JUMP, 32'h8, 32'hFFFF_FFFC, 0, 0, 1, 0); // c19
    checkOutput("c19_req", imem_req, 0);
    checkOutput("c19_addr", imem_addr, 32'h1008);
    applyStimulus(0, 0, 1, NPC_JUMP, 32'h8, 32'hFFFF_FFFC, 0, 0, 1, 0); // c20
    checkOutput("c20_req", imem_req, 0);
    plain(1);                                       // c21: wrapped jump target
    checkOutput("c21_req", imem_req, 1);
    checkOutput("c21_addr", imem_addr, 32'h4);
    applyStimulus(0, 0, 0, NPC_PLUS4, 0, 0, 0, 0, 1, 3);   // c22: 0x8 response slow
    applyStimulus(1, 0, 0, NPC_PLUS4, 0, 0, 0, 0, 0, 0);   // c23: reset in S_WAIT
    applyStimulus(0, 0, 0, NPC_PLUS4, 0, 0, 0, 0, 0, 1);   // c24
    checkOutput("c24_req", imem_req, 0);
    checkOutput("c24_addr", imem_addr, 32'h0);
    checkOutput("c24_valid", valid_IF_ID, 0);
    for (int i = 25; i <= 27; i++) begin
      plain(i == 27);
      checkOutput($sformatf("c%0d_req", i), imem_req, 1);
      checkOutput($sformatf("c%0d_addr", i), imem_addr, 32'h0);
      checkOutput($sformatf("c%0d_valid", i), valid_IF_ID, 0);
    end
    plain(1);                                       // c28
    checkOutput("c28_req", imem_req, 1);
    checkOutput("c28_addr", imem_addr, 32'h4);
    checkOutput("c28_valid", valid_IF_ID, 0);
    for (int i = 29; i <= 33; i++) plain(0);
    checkOutput("c33_req", imem_req, 1);
    checkOutput("c33_addr", imem_addr, 32'h8);
    checkOutput("sb_drain", expQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
